mul12u_acc_stage: RTL and testbench
===================================

// Module: mul12u_acc_stage
// PURPOSE
//  Downstream accumulate stage for the truncating 12x12 unsigned approximate multipliers.
//  Consumes a stream of 24-bit products and sums each packet of products (terminated by in_last).
//  Presents one dot-product result per packet on a valid/ready output.
//  Upstream products have TRUNC guaranteed-zero LSBs, so only the upper bits are stored.
//  Any violation of that guarantee is flagged.
// PARAMETERS
//  PW     24  product width (in_prod)
//  AW     32  result width (out_sum); AW >= PW
//  TRUNC  12  number of product LSBs guaranteed zero by upstream; TRUNC < PW
//  CW     8   packet beat-counter width (out_count)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_prod/in_last valid
//  in_ready   out  1      stage accepts a beat
//  in_prod    in   PW     product from multiplier
//  in_last    in   1      final beat of packet
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  AW     packet sum; low TRUNC bits always 0
//  out_count  out  CW     beats in packet (saturating)
//  out_sat    out  1      sum saturated during this packet
//  lsb_err    out  1      sticky: some in_prod[TRUNC-1:0] != 0 since reset
// BEHAVIOUR
//  - Reset and one clock only. On rst (sampled at clk):
//    - state=ACC; acc=0; count=0; sat=0; lsb_err=0; out_valid=0.
//    - rst overrides all handshakes, including mid-packet or while in HOLD.
//  - Storage: acc is (AW-TRUNC) bits.
//    - Beat added = in_prod[PW-1:TRUNC], zero-extended.
//    - out_sum = {acc, TRUNC'b0}.
//  - FSM, two states:
//    - ACC: in_ready=1, out_valid=0.
//      - Beat accepted when in_valid & in_ready.
//      - acc <= sat_add(acc, beat); count <= count+1, holding at 2^CW-1.
//      - sat <= sat | overflow.
//      - If in_last also set: go to HOLD.
//    - HOLD: in_ready=0, out_valid=1.
//      - out_sum/out_count/out_sat are stable and reflect the completed packet, including the last beat.
//      - On out_ready: clear acc, count and sat; go to ACC.
//      - No new beat is accepted in the release cycle.
//  - Saturation: if the add overflows (AW-TRUNC) bits, acc <= all ones.
//    - out_sum is then 2^AW - 2^TRUNC.
//    - Further beats in the same packet leave acc at that value.
//  - Latency: out_valid rises on the cycle after the last-beat handshake.
//    - Minimum packet period is 2 cycles for 1 beat; in general N+1 cycles for N beats.
//  - lsb_err is set on any accepted beat with in_prod[TRUNC-1:0] != 0.
//    - The offending LSBs are discarded; the beat still accumulates.
//    - lsb_err is cleared only by rst.
//  - in_valid=0 in ACC: no state change; a packet may stall indefinitely between beats.
//  - in_last on the first beat is legal: single-beat packet.
//  - Outputs driven from registers/state only; no combinational in->out path.
//  - in_ready depends on state only.
// TESTING
//  1. Beats 4096, 8192, 16257024; last on 3rd -> out_valid next cycle; out_sum=16269312, out_count=3, out_sat=0.
//  2. Same packet with out_ready=0 for 5 cycles -> out_valid held, out_sum stable, in_ready=0; release -> next cycle in_ready=1, acc=0.
//  3. AW=24: beats 16257024, 16257024 (last) -> out_sum=16773120, out_sat=1; following packet 4096 (last) -> out_sum=4096, out_sat=0.
//  4. Beat 4097 (last) -> out_sum=4096, lsb_err=1; lsb_err stays 1 across next packets until rst.
//  5. Two beats of 4096 accepted, then rst 1 cycle, then 8192 (last) -> out_sum=8192, out_count=1.
//  6. CW=2: five beats of 4096 (last on 5th) -> out_sum=20480, out_count=3 (saturated).

Source files
------------

// File: rtl/mul12u_acc_stage.sv
// Accumulate stage for truncated 12x12 unsigned multiplier products: sums each
// packet of products and holds one saturating result per packet on a valid/ready output.
module mul12u_acc_stage #(
  parameter int PW    = 24,
  parameter int AW    = 32,
  parameter int TRUNC = 12,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_sat,
  output logic          lsb_err
);

  localparam int SW = AW - TRUNC;
  localparam int BW = PW - TRUNC;

  typedef enum logic {
    ST_ACC,
    ST_HOLD
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] acc;
  logic [CW-1:0] count;
  logic          sat;
  logic          lsb_seen;

  logic          beat_fire;
  logic          release_fire;
  logic [SW:0]   sum_wide;
  logic          overflow;
  logic          lsb_bad;

  assign beat_fire    = in_valid && (state == ST_ACC);
  assign release_fire = out_ready && (state == ST_HOLD);

  // One extra bit catches carry-out of the stored upper product bits.
  assign sum_wide = {1'b0, acc} + {{(SW + 1 - BW){1'b0}}, in_prod[PW-1:TRUNC]};
  assign overflow = sum_wide[SW];
  assign lsb_bad  = |in_prod[TRUNC-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACC:  if (beat_fire && in_last) state_next = ST_HOLD;
      ST_HOLD: if (out_ready) state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      sat      <= 1'b0;
      lsb_seen <= 1'b0;
    end else if (release_fire) begin
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else if (beat_fire) begin
      acc   <= overflow ? {SW{1'b1}} : sum_wide[SW-1:0];
      count <= (&count) ? count : count + 1'b1;
      sat   <= sat | overflow;
      if (lsb_bad) begin
        lsb_seen <= 1'b1;
      end
    end
  end

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);
  assign out_sum   = {acc, {TRUNC{1'b0}}};
  assign out_count = count;
  assign out_sat   = sat;
  assign lsb_err   = lsb_seen;

endmodule

// File: tb/tb_mul12u_acc_stage.sv
// Self-checking bench for mul12u_acc_stage: three parameterisations share one
// stimulus stream and are compared against an arithmetic packet-sum model.
module tb_mul12u_acc_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [23:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_sat, a_lsb_err;
  logic [31:0] a_out_sum;
  logic [7:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_sat, b_lsb_err;
  logic [23:0] b_out_sum;
  logic [7:0]  b_out_count;
  logic        c_in_ready, c_out_valid, c_out_sat, c_lsb_err;
  logic [31:0] c_out_sum;
  logic [1:0]  c_out_count;

  int     checks = 0;
  int     errors = 0;
  longint true_sum;
  longint beats;
  bit     lsb_seen;
  bit     busy;

  always #5 clk = ~clk;

  mul12u_acc_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
    .out_sat(a_out_sat), .lsb_err(a_lsb_err)
  );

  mul12u_acc_stage #(.AW(24)) u_dut_aw24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
    .out_sat(b_out_sat), .lsb_err(b_lsb_err)
  );

  mul12u_acc_stage #(.CW(2)) u_dut_cw2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_sum(c_out_sum), .out_count(c_out_count),
    .out_sat(c_out_sat), .lsb_err(c_lsb_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Expected result as a mathematical clamp of the exact packet sum.
  function automatic longint expSum(input int aw);
    longint max_acc = (64'sd1 <<< (aw - 12)) - 1;
    return ((true_sum > max_acc) ? max_acc : true_sum) * 4096;
  endfunction

  function automatic longint expCount(input int cw);
    longint max_cnt = (64'sd1 <<< cw) - 1;
    return (beats > max_cnt) ? max_cnt : beats;
  endfunction

  function automatic logic expSat(input int aw);
    return true_sum > ((64'sd1 <<< (aw - 12)) - 1);
  endfunction

  task automatic checkAll();
    checkOutput("a_in_ready",  a_in_ready,  !busy);
    checkOutput("b_in_ready",  b_in_ready,  !busy);
    checkOutput("c_in_ready",  c_in_ready,  !busy);
    checkOutput("a_out_valid", a_out_valid, busy);
    checkOutput("b_out_valid", b_out_valid, busy);
    checkOutput("c_out_valid", c_out_valid, busy);
    checkOutput("a_out_sum",   a_out_sum,   expSum(32));
    checkOutput("b_out_sum",   b_out_sum,   expSum(24));
    checkOutput("c_out_sum",   c_out_sum,   expSum(32));
    checkOutput("a_out_count", a_out_count, expCount(8));
    checkOutput("b_out_count", b_out_count, expCount(8));
    checkOutput("c_out_count", c_out_count, expCount(2));
    checkOutput("a_out_sat",   a_out_sat,   expSat(32));
    checkOutput("b_out_sat",   b_out_sat,   expSat(24));
    checkOutput("c_out_sat",   c_out_sat,   expSat(32));
    checkOutput("a_lsb_err",   a_lsb_err,   lsb_seen);
    checkOutput("b_lsb_err",   b_lsb_err,   lsb_seen);
    checkOutput("c_lsb_err",   c_lsb_err,   lsb_seen);
  endtask

  // Drive one cycle of inputs, advance the model by what the edge will do, then check.
  task automatic applyStimulus(input bit rs, input bit v, input logic [23:0] p, input bit l, input bit r);
    rst       = rs;
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = r;
    if (rs) begin
      true_sum = 0; beats = 0; lsb_seen = 0; busy = 0;
    end else if (busy) begin
      if (r) begin
        busy = 0; true_sum = 0; beats = 0;
      end
    end else if (v) begin
      true_sum += longint'(p) / 4096;
      beats++;
      if (p % 4096 != 0) lsb_seen = 1;
      if (l) busy = 1;
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  function automatic logic [23:0] randProd();
    int sel = $urandom_range(0, 9);
    if (sel < 7)       return {12'($urandom), 12'h000};
    else if (sel < 9)  return {5'h1F, 7'($urandom), 12'h000};
    else               return 24'($urandom);
  endfunction

  initial begin
    true_sum = 0; beats = 0; lsb_seen = 0; busy = 0;
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 24'd4096, 1, 1);

    // Three-beat packet, then held for five cycles with a beat offered meanwhile.
    applyStimulus(0, 1, 24'd4096, 0, 0);
    applyStimulus(0, 0, 24'd4096, 0, 0);
    applyStimulus(0, 1, 24'd8192, 0, 0);
    applyStimulus(0, 1, 24'd16257024, 1, 0);
    checkOutput("t1_sum_const", a_out_sum, 64'd16269312);
    checkOutput("t1_count_const", a_out_count, 64'd3);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 24'd8192, 1, 0);
    checkOutput("t2_sum_held", a_out_sum, 64'd16269312);
    applyStimulus(0, 1, 24'd8192, 1, 1);
    checkOutput("t2_acc_clear", a_out_sum, 64'd0);

    // Saturation in the narrow-accumulator instance, cleared for the next packet.
    applyStimulus(0, 1, 24'd16257024, 0, 0);
    applyStimulus(0, 1, 24'd16257024, 1, 0);
    checkOutput("t3_sat_sum", b_out_sum, 64'd16773120);
    checkOutput("t3_sat_flag", b_out_sat, 64'd1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 24'd4096, 1, 0);
    checkOutput("t3_next_sum", b_out_sum, 64'd4096);
    checkOutput("t3_next_sat", b_out_sat, 64'd0);
    applyStimulus(0, 0, 0, 0, 1);

    // Nonzero discarded LSBs set the sticky flag.
    applyStimulus(0, 1, 24'd4097, 1, 0);
    checkOutput("t4_sum", a_out_sum, 64'd4096);
    checkOutput("t4_lsb", a_lsb_err, 64'd1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 24'd4096, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_lsb_sticky", a_lsb_err, 64'd1);

    // Reset mid-packet discards the partial sum and the sticky flag.
    applyStimulus(0, 1, 24'd4096, 0, 0);
    applyStimulus(0, 1, 24'd4096, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 24'd8192, 1, 0);
    checkOutput("t5_sum", a_out_sum, 64'd8192);
    checkOutput("t5_count", a_out_count, 64'd1);
    checkOutput("t5_lsb_clear", a_lsb_err, 64'd0);
    applyStimulus(0, 0, 0, 0, 1);

    // Beat counter saturation in the 2-bit-counter instance.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 24'd4096, (i == 4), 0);
    checkOutput("t6_sum", c_out_sum, 64'd20480);
    checkOutput("t6_count_sat", c_out_count, 64'd3);
    checkOutput("t6_count_wide", a_out_count, 64'd5);
    applyStimulus(0, 0, 0, 0, 1);

    // Randomized traffic with stalls, backpressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 3) != 0),
                    randProd(),
                    ($urandom_range(0, 9) < 3),
                    ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
